// File: rtl/pool2_stream.sv
// pool2_stream -- streaming 2x2 / stride-2 pooling over a raster-order frame.
//
// Pixels enter one per accepted beat in raster order. Each 2x2 window emits one
// pooled pixel, and every channel is reduced on its own. Frame cells that fall
// outside the image (odd IMG_W / IMG_H) count as value 0.
//
// Reduction per window:
//   * default : unsigned max of the 4 samples.
//   * POOL2_AVG_EN defined, avg_sel=1 : (sum of 4 samples) >> 2, truncated.
//     Padded cells add 0 and the divisor stays 4.
// When the macro POOL2_AVG_EN is not defined, the avg_sel port and all adder
// logic are absent.
//
// How the window is built:
//   * The even-column sample is held in a register.
//   * The pair result is formed at the odd column, or at the last column when
//     IMG_W is odd (paired with 0).
//   * Even rows park the pair result in a line buffer of OUT_W entries.
//   * Odd rows combine the pair result with the line buffer entry and load the
//     output register.
//   * When IMG_H is odd, the final row combines with 0 instead.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous, active-high reset
//   avg_sel    (POOL2_AVG_EN only) 1 = average. Sampled on pixel (0,0) and
//              held for the whole frame.
//   in_valid   input beat valid
//   in_ready   input beat accepted when in_valid && in_ready
//   in_data    CH*BW pixel; channel c at [c*BW +: BW]
//   out_valid  pooled pixel valid
//   out_ready  downstream accepts when out_valid && out_ready
//   out_data   CH*BW pooled pixel, same packing as in_data
//   out_last   set with the final pooled pixel of a frame
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// While out_valid && !out_ready, out_data and out_last are held stable.
// in_ready = !out_valid || out_ready, so a new result can replace the one
// leaving in the same cycle. Latency from the window-completing beat to
// out_valid is 1 cycle.
module pool2_stream #(
  parameter int BW    = 8,
  parameter int CH    = 1,
  parameter int IMG_W = 25,
  parameter int IMG_H = 25
) (
  input  logic          clk,
  input  logic          rst,
`ifdef POOL2_AVG_EN
  input  logic          avg_sel,
`endif
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CH*BW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CH*BW-1:0] out_data,
  output logic          out_last
);

  localparam int OUT_W = (IMG_W + 1) / 2;
  localparam int OUT_H = (IMG_H + 1) / 2;
  localparam bit COL_PAD_EN = (2 * OUT_W > IMG_W);  // odd width: last column pads
  localparam bit ROW_PAD_EN = (2 * OUT_H > IMG_H);  // odd height: last row pads
  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);
  localparam int LIW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
`ifdef POOL2_AVG_EN
  localparam int PW = BW + 1;  // pair sum needs one extra bit
`else
  localparam int PW = BW;
`endif
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]       col;
  logic [RW-1:0]       row;
  logic [CH*BW-1:0]    hold;
  logic [CH*PW-1:0]    lb [OUT_W];
  logic [LIW-1:0]      lb_idx;
  logic [CH*PW-1:0]    lb_rd;
  logic [CH*PW-1:0]    pair_all;
  logic [CH*BW-1:0]    res_all;
  logic                accept, col_end, row_end, pair_end, row_pad, win_done;
  logic [BW-1:0]       sa, sb;
  logic [PW-1:0]       sp, st;
`ifdef POOL2_AVG_EN
  logic                avg_mode;
  logic [BW+1:0]       ssum;
`endif

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign col_end  = (col == COL_LAST);
  assign row_end  = (row == ROW_LAST);
  assign pair_end = col[0] || (COL_PAD_EN && col_end);
  assign row_pad  = ROW_PAD_EN && row_end;
  assign win_done = accept && pair_end && (row[0] || row_pad);
  assign lb_idx   = LIW'(col >> 1);
  assign lb_rd    = lb[lb_idx];

  // Per-channel pair reduction and window completion.
  always_comb begin
    pair_all = '0;
    res_all  = '0;
    sa = '0;
    sb = '0;
    sp = '0;
    st = '0;
`ifdef POOL2_AVG_EN
    ssum = '0;
`endif
    for (int c = 0; c < CH; c++) begin
      // Odd column pairs the held sample with the new one. The padded last
      // column pairs the new sample with 0.
      sa = col[0] ? hold[c*BW +: BW] : in_data[c*BW +: BW];
      sb = col[0] ? in_data[c*BW +: BW] : '0;
`ifdef POOL2_AVG_EN
      sp = avg_mode ? (PW'(sa) + PW'(sb)) : PW'((sa > sb) ? sa : sb);
`else
      sp = (sa > sb) ? sa : sb;
`endif
      st = row_pad ? '0 : lb_rd[c*PW +: PW];
      pair_all[c*PW +: PW] = sp;
`ifdef POOL2_AVG_EN
      ssum = (BW+2)'(sp) + (BW+2)'(st);
      res_all[c*BW +: BW] = avg_mode ? BW'(ssum >> 2) : BW'((sp > st) ? sp : st);
`else
      res_all[c*BW +: BW] = (sp > st) ? sp : st;
`endif
    end
  end

  // Raster position of the next beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

`ifdef POOL2_AVG_EN
  always_ff @(posedge clk) begin
    if (rst) avg_mode <= 1'b0;
    else if (accept && col == '0 && row == '0) avg_mode <= avg_sel;
  end
`endif

  // Even-column holding register and line buffer. Neither needs a reset:
  // both are always rewritten before they are read.
  always_ff @(posedge clk) begin
    if (accept && !col[0]) hold <= in_data;
  end

  always_ff @(posedge clk) begin
    if (accept && pair_end && !row[0] && !row_pad) lb[lb_idx] <= pair_all;
  end

  // Output register. A new window result takes priority over draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (win_done) begin
      out_valid <= 1'b1;
      out_data  <= res_all;
      out_last  <= row_end && col_end;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pool2_stream.sv
// Bench for pool2_stream: a 4x4 two-channel instance (dut_a) and a 3x3
// single-channel instance (dut_b). The model pools whole frames with plain
// loops into expected queues. Per-instance compare processes check every
// output handshake and the hold/ready rules. Literal tables pin the model.
module tb_pool2_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // frame images: [frame][row][col][channel]
  int img [2][4][4][2];

  logic a_rst, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
  logic [15:0] a_in_data, a_out_data;
  logic b_rst, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
  logic [7:0] b_in_data, b_out_data;
`ifdef POOL2_AVG_EN
  logic a_avg_sel = 1'b0;
  logic b_avg_sel = 1'b0;
`endif

  logic [16:0] exp_a[$];
  logic [16:0] exp_b[$];
  logic [15:0] log_a[$];
  logic [7:0]  log_b[$];
  logic        log_b_last[$];
  logic        a_done;

  pool2_stream #(.BW(8), .CH(2), .IMG_W(4), .IMG_H(4)) dut_a (
    .clk(clk), .rst(a_rst),
`ifdef POOL2_AVG_EN
    .avg_sel(a_avg_sel),
`endif
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_last(a_out_last)
  );

  pool2_stream #(.BW(8), .CH(1), .IMG_W(3), .IMG_H(3)) dut_b (
    .clk(clk), .rst(b_rst),
`ifdef POOL2_AVG_EN
    .avg_sel(b_avg_sel),
`endif
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_last(b_out_last)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  // Behavioural model: max over each 2x2 window with out-of-frame cells as 0.
  task automatic model_frame(input int f, input int w, input int h, input int nch, input bit to_a);
    int ow, oh, m, y, x;
    logic [16:0] e;
    ow = (w + 1) / 2;
    oh = (h + 1) / 2;
    for (int r = 0; r < oh; r++) begin
      for (int c = 0; c < ow; c++) begin
        e = '0;
        for (int ch = 0; ch < nch; ch++) begin
          m = 0;
          for (int dy = 0; dy < 2; dy++) begin
            for (int dx = 0; dx < 2; dx++) begin
              y = 2 * r + dy;
              x = 2 * c + dx;
              if (y < h && x < w && img[f][y][x][ch] > m) m = img[f][y][x][ch];
            end
          end
          e[ch*8 +: 8] = 8'(m);
        end
        e[16] = (r == oh - 1) && (c == ow - 1);
        if (to_a) exp_a.push_back(e);
        else exp_b.push_back(e);
      end
    end
  endtask

  // Compare process, dut_a.
  logic        a_prev_stall = 1'b0;
  logic [16:0] a_prev_out   = '0;
  always @(negedge clk) begin
    logic [16:0] e;
    if (a_rst) begin
      a_prev_stall = 1'b0;
    end else begin
      check("a_in_ready_rule", a_in_ready, !a_out_valid || a_out_ready);
      if (a_prev_stall) begin
        check("a_stall_valid", a_out_valid, 1);
        check("a_stall_data", {a_out_last, a_out_data}, a_prev_out);
      end
      if (a_out_valid && a_out_ready) begin
        if (exp_a.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL a_extra_output: got %0d expected no output", a_out_data);
        end else begin
          e = exp_a.pop_front();
          check("a_out", {a_out_last, a_out_data}, e);
        end
        log_a.push_back(a_out_data);
      end
      a_prev_stall = a_out_valid && !a_out_ready;
      a_prev_out   = {a_out_last, a_out_data};
    end
  end

  // Compare process, dut_b.
  always @(negedge clk) begin
    logic [16:0] e;
    if (!b_rst) begin
      check("b_in_ready_rule", b_in_ready, !b_out_valid || b_out_ready);
      if (b_out_valid && b_out_ready) begin
        if (exp_b.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL b_extra_output: got %0d expected no output", b_out_data);
        end else begin
          e = exp_b.pop_front();
          check("b_out", {b_out_last, 8'h00, b_out_data}, e);
        end
        log_b.push_back(b_out_data);
        log_b_last.push_back(b_out_last);
      end
    end
  end

  // Present one beat and hold it until accepted. Valid stays high on return.
  task automatic a_beat(input logic [15:0] d);
    a_in_valid = 1'b1;
    a_in_data  = d;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (a_in_ready) break;
      if (n >= 200) begin
        timeout_fail("a_in_ready_wait");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic b_beat(input logic [7:0] d);
    b_in_valid = 1'b1;
    b_in_data  = d;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (b_in_ready) break;
      if (n >= 200) begin
        timeout_fail("b_in_ready_wait");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic a_send_frame(input int f, input bit lat_chk);
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 4; x++) begin
        a_beat({8'(img[f][y][x][1]), 8'(img[f][y][x][0])});
        if (lat_chk && (y % 2 == 1) && (x % 2 == 1)) begin
          a_in_valid = 1'b0;
          @(negedge clk);
          check("a_latency_valid", a_out_valid, 1);
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic b_send_frame(input int f);
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 3; x++)
        b_beat(8'(img[f][y][x][0]));
  endtask

  task automatic a_drain();
    a_in_valid = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (exp_a.size() == 0) break;
      if (n == 199) timeout_fail("a_drain");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic b_drain();
    b_in_valid = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (exp_b.size() == 0) break;
      if (n == 199) timeout_fail("b_drain");
    end
    @(posedge clk);
    #1;
  endtask

  // Hand-computed results for the 4x4 ramp: ch0 = 0..15, ch1 = 255-ch0.
  task automatic check_ramp_log(input string name);
    logic [7:0] lit0 [4];
    logic [7:0] lit1 [4];
    lit0 = '{8'd5, 8'd7, 8'd13, 8'd15};
    lit1 = '{8'd255, 8'd253, 8'd247, 8'd245};
    check({name, "_count"}, log_a.size(), 4);
    for (int k = 0; k < 4 && k < log_a.size(); k++) begin
      check({name, "_ch0"}, log_a[k][7:0], lit0[k]);
      check({name, "_ch1"}, log_a[k][15:8], lit1[k]);
    end
    log_a.delete();
  endtask

  task automatic fill_ramp(input int f);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) begin
        img[f][y][x][0] = y * 4 + x;
        img[f][y][x][1] = 255 - (y * 4 + x);
      end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] lit_b [8];
    logic [7:0] lit_d [4];
    logic [3:0] pat;
    a_rst = 1'b1; b_rst = 1'b1;
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    a_in_data = '0; b_in_data = '0;
    a_out_ready = 1'b1; b_out_ready = 1'b1;
    a_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    a_rst = 1'b0; b_rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("a_rst_valid", a_out_valid, 0);
    check("a_rst_last", a_out_last, 0);
    check("a_rst_data", a_out_data, 0);
    check("b_rst_valid", b_out_valid, 0);
    check("b_rst_data", b_out_data, 0);
    @(posedge clk);
    #1;

    // 4x4 ramp, two channels, out_ready high, latency checked per window
    fill_ramp(0);
    model_frame(0, 4, 4, 2, 1'b1);
    a_send_frame(0, 1'b1);
    a_drain();
    check_ramp_log("ramp");

    // Back-pressure: out_ready low for 3 cycles once the first result is valid
    model_frame(0, 4, 4, 2, 1'b1);
    a_out_ready = 1'b0;
    fork
      begin
        a_send_frame(0, 1'b0);
        a_in_valid = 1'b0;
      end
      begin
        for (int n = 0; ; n++) begin
          @(negedge clk);
          if (a_out_valid) break;
          if (n >= 200) begin
            timeout_fail("a_first_valid");
            break;
          end
        end
        check("stall_in_ready", a_in_ready, 0);
        check("stall_data", a_out_data[7:0], 5);
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          check("stall_in_ready", a_in_ready, 0);
          check("stall_data", a_out_data[7:0], 5);
        end
        @(posedge clk);
        #1;
        a_out_ready = 1'b1;
      end
    join
    a_drain();
    check_ramp_log("stall");

    // Reset after 6 beats of a frame, then a full frame
    for (int i = 0; i < 6; i++) a_beat({8'(255 - i), 8'(i)});
    a_in_valid = 1'b0;
    a_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    a_rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", a_out_valid, 0);
    check("midrst_last", a_out_last, 0);
    @(posedge clk);
    #1;
    log_a.delete();
    model_frame(0, 4, 4, 2, 1'b1);
    a_send_frame(0, 1'b0);
    a_drain();
    check_ramp_log("midrst");

    // Two scrambled frames back to back with out_ready toggling
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 16; i++) begin
        img[f][i/4][i%4][0] = (i * 37 + 11 + f * 90) % 256;
        img[f][i/4][i%4][1] = (i * 91 + 3 + f * 17) % 256;
      end
    model_frame(0, 4, 4, 2, 1'b1);
    model_frame(1, 4, 4, 2, 1'b1);
    pat = 4'b1011;
    a_done = 1'b0;
    fork
      begin
        a_send_frame(0, 1'b0);
        a_send_frame(1, 1'b0);
        a_in_valid = 1'b0;
        a_done = 1'b1;
      end
      begin
        for (int k = 0; !a_done && k < 2000; k++) begin
          @(posedge clk);
          #1;
          a_out_ready = pat[k % 4];
        end
      end
    join
    a_out_ready = 1'b1;
    a_drain();
    log_a.delete();

    // 3x3 frame 1..9, twice back to back
    for (int i = 0; i < 9; i++) img[0][i/3][i%3][0] = i + 1;
    model_frame(0, 3, 3, 1, 1'b0);
    model_frame(0, 3, 3, 1, 1'b0);
    b_send_frame(0);
    b_send_frame(0);
    b_drain();
    lit_b = '{8'd5, 8'd6, 8'd8, 8'd9, 8'd5, 8'd6, 8'd8, 8'd9};
    check("b_count", log_b.size(), 8);
    for (int k = 0; k < 8 && k < log_b.size(); k++) begin
      check("b_lit_data", log_b[k], lit_b[k]);
      check("b_lit_last", log_b_last[k], (k % 4) == 3);
    end
    log_b.delete();
    log_b_last.delete();

    // 3x3 descending 9..1 with a gap before each beat
    for (int i = 0; i < 9; i++) img[1][i/3][i%3][0] = 9 - i;
    model_frame(1, 3, 3, 1, 1'b0);
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 3; x++) begin
        b_in_valid = 1'b0;
        @(posedge clk);
        #1;
        b_beat(8'(img[1][y][x][0]));
      end
    b_drain();
    lit_d = '{8'd9, 8'd7, 8'd3, 8'd1};
    check("b_desc_count", log_b.size(), 4);
    for (int k = 0; k < 4 && k < log_b.size(); k++)
      check("b_desc_data", log_b[k], lit_d[k]);

    check("a_exp_left", exp_a.size(), 0);
    check("b_exp_left", exp_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
